// File: rtl/sprite_ram_writer.sv
// sprite_ram_writer: drives port A of a dual-port sprite RAM.
// It either streams a 55x55 bitmap of palette indices in raster order or
// fills the whole sprite with one constant index.
// The address map is addr = x + y*SPRITE_DIM. The address counter is
// advanced in step with x/y, so no multiplier is needed.
//
// Handshake: a pixel is accepted on a rising clock edge when
// pix_valid & pix_ready are both high. pix_ready is high in every STREAM
// cycle and low otherwise. pix_ready is a pure function of the state, so it
// does not depend on pix_valid. Each accepted pixel appears as a registered
// write (wr_en/wr_addr/wr_data) in the following cycle. A pixel accepted in
// the same cycle as abort is dropped.
module sprite_ram_writer #(
  parameter int SPRITE_DIM = 55,
  parameter int ADDR_W     = 12,  // SPRITE_DIM*SPRITE_DIM must fit in 2**ADDR_W
  parameter int DATA_W     = 4
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_index,
  input  logic              abort,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(SPRITE_DIM);
  localparam logic [CW-1:0] LAST = CW'(SPRITE_DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FILL   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       x_q, x_d;
  logic [CW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;

  logic accept;
  logic last_px;

  // A pixel is consumed either from the stream handshake or once per FILL cycle.
  always_comb begin
    accept  = !abort && ((state_q == ST_STREAM && pix_valid) || state_q == ST_FILL);
    last_px = (x_q == LAST) && (y_q == LAST);
  end

  // Next-state, counter and write-port logic.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    fill_d    = fill_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Abort has priority over start, even while idle.
        if (start && !abort) begin
          state_d = fill_mode ? ST_FILL : ST_STREAM;
          fill_d  = fill_index;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      ST_STREAM, ST_FILL: begin
        if (abort) begin
          state_d = ST_IDLE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end else if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = (state_q == ST_FILL) ? fill_q : pix_data;
          if (last_px) begin
            // Final pixel: done fires alongside the last write, and the
            // block is idle (and can accept a new start) the cycle after.
            done_d  = 1'b1;
            state_d = ST_IDLE;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
            if (x_q == LAST) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
      end
    endcase
  end

  // State, counters and registered write port; reset clears everything.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      fill_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      fill_q    <= fill_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  // Status outputs decoded from state alone.
  always_comb begin
    pix_ready = (state_q == ST_STREAM);
    busy      = (state_q == ST_STREAM) || (state_q == ST_FILL);
    dbg_state = state_q;
    wr_en     = wr_en_q;
    wr_addr   = wr_addr_q;
    wr_data   = wr_data_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Bench for sprite_ram_writer: a pixel-count model predicts every output
// each cycle, and a queue of expected writes is checked against wr_en
// pulses. Directed runs cover continuous/gapped stream, fill timing, abort,
// mid-stream reset and random control traffic.
module tb_sprite_ram_writer;
  localparam int DIM = 55;
  localparam int N   = DIM * DIM;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, fill_mode = 1'b0, abort = 1'b0, pix_valid = 1'b0;
  logic [3:0] fill_index = 4'h0, pix_data = 4'h0;
  logic       pix_ready, wr_en, busy, done;
  logic [11:0] wr_addr;
  logic [3:0] wr_data;
  logic [1:0] dbg_state;

  sprite_ram_writer dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .start(start), .fill_mode(fill_mode),
    .fill_index(fill_index), .abort(abort), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 vga_clk = ~vga_clk;
  int cyc = 0;
  initial forever begin
    @(posedge vga_clk);
    cyc++;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 idle, 1 stream, 2 fill; m_count = pixels written so far.
  int         m_mode = 0, m_count = 0;
  logic [3:0] m_fval = 4'h0;
  logic       e_wr_en = 1'b0, e_done = 1'b0;
  logic [11:0] e_addr = 12'h0;
  logic [3:0] e_data = 4'h0;
  logic [15:0] exp_q[$];

  initial forever begin
    @(posedge vga_clk or negedge reset_n);
    if (!reset_n) begin
      m_mode = 0; m_count = 0; e_wr_en = 0; e_done = 0; e_addr = 0; e_data = 0;
      exp_q.delete();
    end else begin
      e_wr_en = 0;
      e_done  = 0;
      if (m_mode == 0) begin
        if (start && !abort) begin
          m_mode = fill_mode ? 2 : 1;
          m_fval = fill_index;
          m_count = 0;
        end
      end else if (abort) begin
        m_mode = 0;
        m_count = 0;
      end else if (m_mode == 2 || pix_valid) begin
        e_wr_en = 1;
        e_addr  = m_count[11:0];
        e_data  = (m_mode == 2) ? m_fval : pix_data;
        exp_q.push_back({e_addr, e_data});
        m_count++;
        if (m_count == N) begin
          e_done = 1;
          m_mode = 0;
          m_count = 0;
        end
      end
    end
  end

  // ---------------- compare process + write log ----------------
  int wr_cnt = 0, done_cnt = 0, first_wr_cyc = -1, last_wr_cyc = -1, done_cyc = -1;
  logic [3:0] tb_ram [0:N-1];
  logic [15:0] w;

  initial forever begin
    @(negedge vga_clk);
    chk("wr_en", {31'd0, wr_en}, {31'd0, e_wr_en});
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("busy", {31'd0, busy}, {31'd0, (m_mode != 0)});
    chk("pix_ready", {31'd0, pix_ready}, {31'd0, (m_mode == 1)});
    chk("wr_addr", {20'd0, wr_addr}, {20'd0, e_addr});
    chk("wr_data", {28'd0, wr_data}, {28'd0, e_data});
    if (wr_en) begin
      if (exp_q.size() == 0) chk("sb_unexpected_write", {20'd0, wr_addr}, 32'hFFFF_FFFF);
      else begin
        w = exp_q.pop_front();
        chk("sb_write", {16'd0, wr_addr, wr_data}, {16'd0, w});
      end
      wr_cnt++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      if (int'(wr_addr) < N) tb_ram[wr_addr] = wr_data;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  logic [3:0] sent [0:DIM-1][0:DIM-1];
  int start_cyc = 0;

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic clear_log();
    wr_cnt = 0; done_cnt = 0; first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
    for (int a = 0; a < N; a++) tb_ram[a] = 4'h0;
  endtask

  task automatic do_start(input logic fm, input logic [3:0] fi);
    start = 1; fill_mode = fm; fill_index = fi;
    start_cyc = cyc;
    tick();
    start = 0; fill_mode = 1'($urandom); fill_index = 4'($urandom);
  endtask

  // Streams the whole sprite in raster order. gap idle cycles follow each
  // pixel. Optionally aborts, resets or pulses start at a given pixel index.
  task automatic stream_px(input int gap, input logic rnd, input int abort_at,
                           input int reset_at, input int busy_start_at);
    for (int y = 0; y < DIM; y++) begin
      for (int x = 0; x < DIM; x++) begin
        int idx;
        logic [3:0] d;
        idx = x + y * DIM;
        d = rnd ? 4'($urandom) : idx[3:0];
        sent[y][x] = d;
        if (idx == abort_at) begin
          abort = 1; pix_valid = 1; pix_data = d;
          tick();
          abort = 0; pix_valid = 0;
          return;
        end
        if (idx == reset_at) begin
          pix_valid = 0;
          tick();
          reset_n = 0;
          #1;
          chk("rst_mid_wr_en", {31'd0, wr_en}, 32'd0);
          chk("rst_mid_busy", {31'd0, busy}, 32'd0);
          chk("rst_mid_pix_ready", {31'd0, pix_ready}, 32'd0);
          chk("rst_mid_wr_addr", {20'd0, wr_addr}, 32'd0);
          tick(); tick();
          reset_n = 1;
          tick();
          return;
        end
        pix_valid = 1; pix_data = d;
        if (idx == busy_start_at) begin
          start = 1; fill_mode = 1; fill_index = 4'hF;
        end
        tick();
        start = 0;
        for (int g = 0; g < gap; g++) begin
          pix_valid = 0; pix_data = 4'($urandom);
          tick();
        end
      end
    end
    pix_valid = 0;
    repeat (3) tick();
  endtask

  task automatic check_ram_vs_sent(input string nm);
    int bad;
    bad = 0;
    for (int a = 0; a < N; a++)
      if (tb_ram[a] !== sent[a / DIM][a % DIM]) bad++;
    chk(nm, bad, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset held with random inputs: every output must sit at zero.
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom); fill_mode = 1'($urandom); abort = 1'($urandom);
      pix_valid = 1'($urandom); pix_data = 4'($urandom); fill_index = 4'($urandom);
      tick();
    end
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    chk("rst_wr_addr", {20'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {28'd0, wr_data}, 32'd0);
    start = 0; abort = 0; pix_valid = 0;
    reset_n = 1;
    repeat (3) tick();
    chk("idle_after_rst", {31'd0, busy}, 32'd0);

    // Continuous stream, pix_data = addr[3:0].
    clear_log();
    do_start(1'b0, 4'h0);
    stream_px(0, 1'b0, -1, -1, -1);
    chk("cont_wr_count", wr_cnt, N);
    chk("cont_done_count", done_cnt, 1);
    chk("cont_first_wr", first_wr_cyc, start_cyc + 2);
    chk("cont_done_cyc", done_cyc, start_cyc + 3026);
    chk("cont_done_on_last", done_cyc, last_wr_cyc);
    chk("cont_ram_3024", {28'd0, tb_ram[3024]}, 32'h0);
    check_ram_vs_sent("cont_ram");

    // Gapped stream: valid 1,0,0,1,0,0,...
    clear_log();
    do_start(1'b0, 4'h0);
    stream_px(2, 1'b1, -1, -1, -1);
    chk("gap_wr_count", wr_cnt, N);
    chk("gap_done_count", done_cnt, 1);
    chk("gap_px_3_2_at_113", {28'd0, tb_ram[113]}, {28'd0, sent[2][3]});
    check_ram_vs_sent("gap_ram");

    // Fill with 4'hA.
    clear_log();
    do_start(1'b1, 4'hA);
    repeat (3035) tick();
    chk("fill_wr_count", wr_cnt, N);
    chk("fill_first_wr", first_wr_cyc, start_cyc + 2);
    chk("fill_last_wr", last_wr_cyc, start_cyc + 3026);
    chk("fill_done_cyc", done_cyc, start_cyc + 3026);
    begin
      int bad;
      bad = 0;
      for (int a = 0; a < N; a++) if (tb_ram[a] !== 4'hA) bad++;
      chk("fill_ram_all_A", bad, 0);
    end

    // Start while busy (ignored) then abort at addr 1000.
    clear_log();
    do_start(1'b0, 4'h0);
    stream_px(0, 1'b1, 1000, -1, 700);
    repeat (10) tick();
    chk("abort_wr_count", wr_cnt, 1000);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    clear_log();
    do_start(1'b0, 4'h0);
    stream_px(0, 1'b1, -1, -1, -1);
    chk("post_abort_wr_count", wr_cnt, N);
    chk("post_abort_done", done_cnt, 1);
    check_ram_vs_sent("post_abort_ram");

    // Start and abort together in IDLE: stays idle.
    start = 1; abort = 1; fill_mode = 0;
    tick();
    start = 0; abort = 0;
    tick();
    chk("start_abort_idle", {31'd0, busy}, 32'd0);

    // Reset pulse mid-stream at addr 500, then a full clean stream.
    clear_log();
    do_start(1'b0, 4'h0);
    stream_px(0, 1'b1, -1, 500, -1);
    chk("rst_mid_wr_count", wr_cnt, 500);
    clear_log();
    do_start(1'b0, 4'h0);
    stream_px(0, 1'b1, -1, -1, -1);
    chk("post_rst_wr_count", wr_cnt, N);
    chk("post_rst_done", done_cnt, 1);
    check_ram_vs_sent("post_rst_ram");

    // Random control traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 19) == 0);
      fill_mode  = 1'($urandom);
      fill_index = 4'($urandom);
      abort      = ($urandom_range(0, 299) == 0);
      pix_valid  = 1'($urandom);
      pix_data   = 4'($urandom);
      tick();
    end
    start = 0; abort = 1; pix_valid = 0;
    tick();
    abort = 0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
